controller_multi_cycle_main: RTL and testbench
==============================================

Name: controller_multi_cycle_main

Overview:
- Moore-style main FSM for the multi-cycle RISC-V (RV32I subset) datapath.
- Sequences fetch, decode, execute, memory and writeback over one shared memory port and one ALU, for the same opcode set as the single-cycle decoder.
- Emits datapath enables and mux selects; ALU function is resolved downstream by the ALU decoder from alu_op.
- Supports variable-latency memory through a mem_ready handshake.

Parameters:
- ILLEGAL_HALT, 0: when 1, an unknown opcode in DECODE enters HALT (terminal until reset); when 0, the FSM returns to FETCH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- opcode  in  7  IR[6:0]; valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write strobe
- ir_write  out  1  IR and OldPC load enable
- reg_write  out  1  register-file write enable
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1 register
- alu_src_b  out  2  00 rs2 register, 01 imm, 10 constant 4
- alu_op  out  2  00 add, 01 sub/compare, 10 R-decode, 11 I-decode
- result_src  out  2  00 ALUOut, 01 mem data, 10 ALU result (unregistered), 11 imm
- instr_done  out  1  one-cycle pulse in the final state of each instruction
- illegal  out  1  one-cycle pulse in DECODE on an unknown opcode
- halted  out  1  high while in HALT

Behaviour:
- Asynchronous reset: state = FETCH.
- While rst is high, pc_write, ir_write, reg_write, mem_write, instr_done and illegal are forced to 0.
- Any output not listed for a state is 0.
- imm_src is decoded from opcode in every state: 19/3/103 → 000; 35 → 001; 99 → 010; 111 → 011; 55 → 100; any other opcode → 000.
- pc_write = pc_update OR (branch AND zero), combinational. pc_update and branch are internal signals.

States and transitions (one state per cycle unless a wait is stated):
- FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - If mem_ready: ir_write=1, pc_update=1, go to DECODE.
  - Else: stay in FETCH with all enables at 0.
- DECODE: a=01, b=01, alu_op=00; computes the branch/jal target into ALUOut. Next state by opcode:
  - 3, 35 → MEM_ADR
  - 51 → EXEC_R
  - 19 → EXEC_I
  - 111 → JUMP
  - 99 → BEQ
  - 55 → LUI
  - 103 → JALR_ADR
  - other → illegal=1, then HALT if ILLEGAL_HALT, else FETCH.
- MEM_ADR: a=10, b=01, alu_op=00. opcode 3 → MEM_READ; 35 → MEM_WRITE.
- MEM_READ: adr_src=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: result_src=01, reg_write=1, instr_done=1 → FETCH.
- MEM_WRITE: adr_src=1, mem_write=1, held every cycle until mem_ready. instr_done=1 in the mem_ready cycle → FETCH.
- EXEC_R: a=10, b=00, alu_op=10 → ALU_WB.
- EXEC_I: a=10, b=01, alu_op=11 → ALU_WB.
- ALU_WB: result_src=00, reg_write=1, instr_done=1 → FETCH.
- BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1, instr_done=1 → FETCH.
- LUI: result_src=11, reg_write=1, instr_done=1 → FETCH.
- JALR_ADR: a=10, b=01, alu_op=00; overwrites ALUOut with rs1+imm → JUMP.
- JUMP: a=01, b=10, alu_op=00, result_src=00, pc_update=1 (PC ← ALUOut target; ALU computes OldPC+4) → ALU_WB (rd ← OldPC+4).
- HALT: halted=1; no enables; exits only via rst.

Boundary conditions:
- Latency in cycles with mem_ready tied high: R/I 4; lw 5; sw 4; beq 3; lui 3; jal 4; jalr 5.
- Each wait cycle adds 1 cycle to any state that waits on mem_ready.
- opcode is ignored in FETCH; in other states it is trusted because IR is stable.
- rst asserted mid-instruction (including mid-wait): FSM returns to FETCH immediately, and no partial write is issued after rst.
- Back-to-back instructions: instr_done in cycle N, FETCH in cycle N+1.

Test Plan:
- R-type (opcode 51), mem_ready=1 → ir_write in cycle 0; a=10/b=00/alu_op=10 in cycle 2; reg_write and instr_done in cycle 3; FETCH in cycle 4.
- lw (3) with mem_ready low for 2 cycles in MEM_READ → MEM_READ persists 3 cycles with adr_src=1; reg_write with result_src=01 exactly once; total 7 cycles.
- sw (35) with mem_ready low in FETCH for 1 cycle and in MEM_WRITE for 2 cycles → mem_write high 3 consecutive cycles, reg_write never 1, instr_done coincides with the mem_ready cycle.
- beq (99) with zero=1, then a second beq with zero=0 → pc_write=1 in the BEQ state only when zero=1; 3 cycles each.
- jalr (103) → state sequence FETCH, DECODE, JALR_ADR, JUMP, ALU_WB; pc_write in JUMP; reg_write with result_src=00 in ALU_WB; imm_src=000 throughout.
- opcode 7'h7F with ILLEGAL_HALT=1 → illegal pulse in DECODE, then halted=1 permanently. Assert rst for 1 cycle mid-HALT → FETCH, all enables 0 while rst is high.

Source files
------------

// File: rtl/controller_multi_cycle_main.sv
// Main sequencing FSM for the multi-cycle RV32I datapath: fetch, decode, execute,
// memory and writeback over a single shared memory port and a single ALU.
module controller_multi_cycle_main #(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [2:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic       instr_done,
    output logic       illegal,
    output logic       halted
);

    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_RTYPE  = 7'd51;
    localparam logic [6:0] OP_ITYPE  = 7'd19;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_JALR   = 7'd103;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_BEQ,
        S_LUI,
        S_JALR_ADR,
        S_JUMP,
        S_HALT
    } state_t;

    // Mux selects that depend only on the state; registered alongside it.
    typedef struct packed {
        logic       adr_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic       halted;
    } sel_t;

    state_t state;
    state_t next_state;
    sel_t   sel_q;
    logic   opcode_known;
    logic   pc_update;
    logic   branch;

    function automatic sel_t sel_for(input state_t s);
        sel_t r;
        r = '0;
        case (s)
            S_FETCH: begin
                r.src_b      = 2'b10;
                r.result_src = 2'b10;
            end
            S_DECODE: begin
                r.src_a = 2'b01;
                r.src_b = 2'b01;
            end
            S_MEM_ADR, S_JALR_ADR: begin
                r.src_a = 2'b10;
                r.src_b = 2'b01;
            end
            S_MEM_READ, S_MEM_WRITE: r.adr_src = 1'b1;
            S_MEM_WB:                r.result_src = 2'b01;
            S_EXEC_R: begin
                r.src_a  = 2'b10;
                r.alu_op = 2'b10;
            end
            S_EXEC_I: begin
                r.src_a  = 2'b10;
                r.src_b  = 2'b01;
                r.alu_op = 2'b11;
            end
            S_BEQ: begin
                r.src_a  = 2'b10;
                r.alu_op = 2'b01;
            end
            S_LUI: r.result_src = 2'b11;
            S_JUMP: begin
                r.src_a = 2'b01;
                r.src_b = 2'b10;
            end
            S_HALT:  r.halted = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        case (opcode)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_JAL, OP_BRANCH, OP_LUI, OP_JALR: opcode_known = 1'b1;
            default:                            opcode_known = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
                    OP_RTYPE:          next_state = S_EXEC_R;
                    OP_ITYPE:          next_state = S_EXEC_I;
                    OP_JAL:            next_state = S_JUMP;
                    OP_BRANCH:         next_state = S_BEQ;
                    OP_LUI:            next_state = S_LUI;
                    OP_JALR:           next_state = S_JALR_ADR;
                    default:           next_state = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            S_MEM_ADR:   next_state = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) next_state = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) next_state = S_FETCH;
            S_EXEC_R, S_EXEC_I: next_state = S_ALU_WB;
            S_JALR_ADR:  next_state = S_JUMP;
            S_JUMP:      next_state = S_ALU_WB;
            S_MEM_WB, S_ALU_WB, S_BEQ, S_LUI: next_state = S_FETCH;
            S_HALT:      next_state = S_HALT;
            default:     next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            sel_q <= sel_for(S_FETCH);
        end else begin
            state <= next_state;
            sel_q <= sel_for(next_state);
        end
    end

    assign adr_src    = sel_q.adr_src;
    assign alu_src_a  = sel_q.src_a;
    assign alu_src_b  = sel_q.src_b;
    assign alu_op     = sel_q.alu_op;
    assign result_src = sel_q.result_src;
    assign halted     = sel_q.halted;

    // Enables react to mem_ready/zero in the same cycle and are held off during reset.
    always_comb begin
        ir_write   = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (!rst) begin
            case (state)
                S_FETCH: begin
                    ir_write  = mem_ready;
                    pc_update = mem_ready;
                end
                S_DECODE: illegal = ~opcode_known;
                S_MEM_WB, S_ALU_WB, S_LUI: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write  = 1'b1;
                    instr_done = mem_ready;
                end
                S_BEQ: begin
                    branch     = 1'b1;
                    instr_done = 1'b1;
                end
                S_JUMP:  pc_update = 1'b1;
                default: ;
            endcase
        end
    end

    assign pc_write = pc_update | (branch & zero);

    always_comb begin
        case (opcode)
            OP_STORE:  imm_src = 3'b001;
            OP_BRANCH: imm_src = 3'b010;
            OP_JAL:    imm_src = 3'b011;
            OP_LUI:    imm_src = 3'b100;
            default:   imm_src = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_controller_multi_cycle_main.sv
// Bench for controller_multi_cycle_main: each instruction is expanded into its expected
// per-cycle output trace (with chosen memory waits) and played against the DUT.
module tb_controller_multi_cycle_main;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write;
    logic [2:0] imm_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic       instr_done, illegal, halted;

    controller_multi_cycle_main #(.ILLEGAL_HALT(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .imm_src(imm_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .result_src(result_src), .instr_done(instr_done), .illegal(illegal),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        mr;
        logic        z;
        logic [6:0]  op;
        logic [15:0] e;
    } ent_t;

    ent_t tq[$];
    int   checks = 0;
    int   errors = 0;
    int   cur_lat = 0, last_lat = 0, memw_cnt = 0, regw_cnt = 0, pcw_cnt = 0;

    function automatic logic [2:0] imm_ref(input logic [6:0] op);
        case (op)
            7'd35:   return 3'b001;
            7'd99:   return 3'b010;
            7'd111:  return 3'b011;
            7'd55:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit known(input logic [6:0] op);
        return op inside {7'd3, 7'd35, 7'd51, 7'd19, 7'd111, 7'd99, 7'd55, 7'd103};
    endfunction

    // Expected outputs excluding imm_src: {pcw,adr,memw,ir,regw,a,b,aop,rs,done,ill,hlt}
    function automatic logic [15:0] mk(input logic adr, input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] aop, input logic [1:0] rs,
                                       input logic ir, input logic pcw, input logic regw,
                                       input logic memw, input logic done, input logic ill,
                                       input logic hlt);
        return {pcw, adr, memw, ir, regw, a, b, aop, rs, done, ill, hlt};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [15:0] e, input logic mr, input logic [6:0] op, input logic z);
        ent_t t;
        t.rst = 1'b0; t.mr = mr; t.z = z; t.op = op; t.e = e;
        tq.push_back(t);
    endtask

    function automatic ent_t rst_ent();
        ent_t t;
        t.rst = 1'b1; t.mr = 1'b1; t.z = rb(); t.op = 7'($urandom_range(0, 127));
        t.e = mk(0, 2'd0, 2'd2, 2'd0, 2'd2, 0, 0, 0, 0, 0, 0, 0);
        return t;
    endfunction

    // Trace of one instruction: fw fetch waits, mw memory waits, z = zero flag in BEQ.
    task automatic build(input logic [6:0] op, input int fw, input int mw, input logic z);
        logic [15:0] alu_wb, jump, mem_adr;
        alu_wb  = mk(0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 1, 0, 1, 0, 0);
        jump    = mk(0, 2'd1, 2'd2, 2'd0, 2'd0, 0, 1, 0, 0, 0, 0, 0);
        mem_adr = mk(0, 2'd2, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < fw; i++)
            push(mk(0, 2'd0, 2'd2, 2'd0, 2'd2, 0, 0, 0, 0, 0, 0, 0), 1'b0, 7'($urandom_range(0, 127)), rb());
        push(mk(0, 2'd0, 2'd2, 2'd0, 2'd2, 1, 1, 0, 0, 0, 0, 0), 1'b1, 7'($urandom_range(0, 127)), rb());
        push(mk(0, 2'd1, 2'd1, 2'd0, 2'd0, 0, 0, 0, 0, 0, !known(op), 0), rb(), op, rb());
        case (op)
            7'd3: begin
                push(mem_adr, rb(), op, rb());
                for (int i = 0; i < mw; i++)
                    push(mk(1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0), 1'b0, op, rb());
                push(mk(1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0), 1'b1, op, rb());
                push(mk(0, 2'd0, 2'd0, 2'd0, 2'd1, 0, 0, 1, 0, 1, 0, 0), rb(), op, rb());
            end
            7'd35: begin
                push(mem_adr, rb(), op, rb());
                for (int i = 0; i < mw; i++)
                    push(mk(1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1, 0, 0, 0), 1'b0, op, rb());
                push(mk(1, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 1, 1, 0, 0), 1'b1, op, rb());
            end
            7'd51: begin
                push(mk(0, 2'd2, 2'd0, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0), rb(), op, rb());
                push(alu_wb, rb(), op, rb());
            end
            7'd19: begin
                push(mk(0, 2'd2, 2'd1, 2'd3, 2'd0, 0, 0, 0, 0, 0, 0, 0), rb(), op, rb());
                push(alu_wb, rb(), op, rb());
            end
            7'd99: push(mk(0, 2'd2, 2'd0, 2'd1, 2'd0, 0, z, 0, 0, 1, 0, 0), rb(), op, z);
            7'd55: push(mk(0, 2'd0, 2'd0, 2'd0, 2'd3, 0, 0, 1, 0, 1, 0, 0), rb(), op, rb());
            7'd103: begin
                push(mem_adr, rb(), op, rb());
                push(jump, rb(), op, rb());
                push(alu_wb, rb(), op, rb());
            end
            7'd111: begin
                push(jump, rb(), op, rb());
                push(alu_wb, rb(), op, rb());
            end
            default: begin
                for (int i = 0; i < 2 + int'($urandom_range(0, 3)); i++)
                    push(mk(0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 1), rb(), 7'($urandom_range(0, 127)), rb());
            end
        endcase
    endtask

    task automatic do_cycle(input ent_t t);
        logic [18:0] got, want;
        rst = t.rst; mem_ready = t.mr; opcode = t.op; zero = t.z;
        @(negedge clk);
        got  = {pc_write, adr_src, mem_write, ir_write, reg_write, imm_src, alu_src_a,
                alu_src_b, alu_op, result_src, instr_done, illegal, halted};
        want = {t.e[15:11], imm_ref(t.op), t.e[10:0]};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cycle t=%0t rst=%0b op=%0d mr=%0b z=%0b: got %h required %h",
                     $time, t.rst, t.op, t.mr, t.z, got, want);
        end
        if (ir_write) cur_lat = 1; else cur_lat++;
        if (instr_done) last_lat = cur_lat;
        memw_cnt += int'(mem_write);
        regw_cnt += int'(reg_write);
        pcw_cnt  += int'(pc_write);
        @(posedge clk);
        #1;
    endtask

    task automatic play(input int abort_at);
        for (int i = 0; i < tq.size(); i++) begin
            if (i == abort_at) begin
                do_cycle(rst_ent());
                break;
            end
            do_cycle(tq[i]);
        end
        tq.delete();
    endtask

    task automatic check_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic clr();
        memw_cnt = 0; regw_cnt = 0; pcw_cnt = 0; last_lat = 0;
    endtask

    task automatic lat_test(input string name, input logic [6:0] op, input int want);
        clr();
        build(op, 0, 0, rb());
        play(-1);
        check_eq(name, last_lat, want);
    endtask

    initial begin
        logic [6:0] legal_ops[8];
        logic [6:0] op;
        int         ab;
        legal_ops = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd111, 7'd99, 7'd55, 7'd103};
        rst = 1'b1; mem_ready = 1'b0; opcode = '0; zero = 1'b0;
        @(posedge clk);
        #1;
        do_cycle(rst_ent());
        do_cycle(rst_ent());

        lat_test("lat_r", 7'd51, 4);
        lat_test("lat_i", 7'd19, 4);
        lat_test("lat_lw", 7'd3, 5);
        lat_test("lat_sw", 7'd35, 4);
        lat_test("lat_beq", 7'd99, 3);
        lat_test("lat_lui", 7'd55, 3);
        lat_test("lat_jal", 7'd111, 4);
        lat_test("lat_jalr", 7'd103, 5);

        clr();
        build(7'd3, 0, 2, 1'b0);
        play(-1);
        check_eq("lw_wait_lat", last_lat, 7);
        check_eq("lw_regw_once", regw_cnt, 1);

        clr();
        build(7'd35, 1, 2, 1'b0);
        play(-1);
        check_eq("sw_memw_cycles", memw_cnt, 3);
        check_eq("sw_no_regw", regw_cnt, 0);

        clr();
        build(7'd99, 0, 0, 1'b1);
        play(-1);
        check_eq("beq_taken_pcw", pcw_cnt, 2);
        clr();
        build(7'd99, 0, 0, 1'b0);
        play(-1);
        check_eq("beq_not_taken_pcw", pcw_cnt, 1);

        build(7'h7F, 0, 0, 1'b0);
        play(-1);
        check_eq("halt_hold", int'(halted), 1);
        do_cycle(rst_ent());
        check_eq("halt_exit", int'(halted), 0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                do op = 7'($urandom_range(0, 127)); while (known(op));
            end else begin
                op = legal_ops[$urandom_range(0, 7)];
            end
            build(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), rb());
            if (!known(op)) tq.push_back(rst_ent());
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, tq.size() - 1)) : -1;
            play(ab);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
